// File: rtl/tsp_pkg.sv
// Shared types and constants for the timeseries predictor fit sequencing.
package tsp_pkg;

    localparam int unsigned TSP_W = 32;
    localparam logic [TSP_W-1:0] DEV_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        ARM,
        WAIT_LOW,
        WAIT_DONE,
        UPDATE,
        FINISH
    } sweep_state_t;

    // True when a window starting at next_si would run past the series end;
    // widened so huge windows/strides cannot wrap back into range.
    function automatic logic window_past_end(input logic [TSP_W:0]   next_si,
                                             input logic [TSP_W-1:0] win,
                                             input logic [TSP_W-1:0] len);
        return ({1'b0, next_si} + {2'b00, win}) > {2'b00, len};
    endfunction

endpackage

// File: rtl/fit_window_sweep_if.sv
// Handshake between the window scheduler (master) and the LinFitDev engine (slave).
interface fit_window_sweep_if;
    import tsp_pkg::*;

    logic [TSP_W-1:0] fit_si;
    logic [TSP_W-1:0] fit_ei;
    logic             fit_start;
    logic             fit_done;
    logic [TSP_W-1:0] fit_deviation;
    logic [TSP_W-1:0] fit_mean;

    modport master (
        output fit_si, fit_ei, fit_start,
        input  fit_done, fit_deviation, fit_mean
    );

    modport slave (
        input  fit_si, fit_ei, fit_start,
        output fit_done, fit_deviation, fit_mean
    );

endinterface

// File: rtl/fit_best_tracker.sv
// Holds the lowest-deviation window seen so far; ties keep the earlier window.
module fit_best_tracker
    import tsp_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic             load,
    input  logic [TSP_W-1:0] cand_si,
    input  logic [TSP_W-1:0] cand_dev,
    input  logic [TSP_W-1:0] cand_mean,
    output logic [TSP_W-1:0] best_si,
    output logic [TSP_W-1:0] best_dev,
    output logic [TSP_W-1:0] best_mean
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            best_si   <= '0;
            best_dev  <= '0;
            best_mean <= '0;
        end else if (clr) begin
            best_si   <= '0;
            best_dev  <= DEV_MAX;
            best_mean <= '0;
        end else if (load && (cand_dev < best_dev)) begin
            best_si   <= cand_si;
            best_dev  <= cand_dev;
            best_mean <= cand_mean;
        end
    end

endmodule

// File: rtl/fit_window_sweep.sv
// Sliding-window scheduler: issues one engine fit per window and keeps the best.
module fit_window_sweep
    import tsp_pkg::*;
#(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             go,
    input  logic [TSP_W-1:0] cfg_len,
    input  logic [TSP_W-1:0] cfg_win,
    input  logic [TSP_W-1:0] cfg_stride,
    output logic             busy,
    output logic             result_valid,
    output logic             err,
    output logic [TSP_W-1:0] best_si,
    output logic [TSP_W-1:0] best_dev,
    output logic [TSP_W-1:0] best_mean,
    output logic [TSP_W-1:0] win_count,
    fit_window_sweep_if.master fit
);

    localparam logic [TSP_W:0] TO_LIM = {1'b0, TIMEOUT[TSP_W-1:0]};

    sweep_state_t     state, state_n;
    logic [TSP_W-1:0] len_q, win_q, stride_q;
    logic [TSP_W-1:0] cur_si;
    logic [TSP_W-1:0] wdog;
    logic [TSP_W:0]   next_si;
    logic             cfg_bad, last_win, counting, wdog_hit;
    logic             trk_clr, trk_load;

    assign cfg_bad  = (win_q == '0) || (stride_q == '0) || (win_q > len_q);
    assign next_si  = {1'b0, cur_si} + {1'b0, stride_q};
    assign last_win = window_past_end(next_si, win_q, len_q);
    assign counting = (state == ARM) || (state == WAIT_LOW) || (state == WAIT_DONE);
    // Abort on the edge where the watchdog would reach TIMEOUT, so FINISH
    // lands exactly TIMEOUT cycles after ARM entry.
    assign wdog_hit = counting && (({1'b0, wdog} + 1'b1) >= TO_LIM);

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (go) state_n = CHECK;
            CHECK:     state_n = cfg_bad ? FINISH : ARM;
            ARM:       if (wdog_hit) state_n = FINISH;
                       else if (fit.fit_done) state_n = WAIT_LOW;
            WAIT_LOW:  state_n = wdog_hit ? FINISH : WAIT_DONE;
            WAIT_DONE: if (wdog_hit) state_n = FINISH;
                       else if (fit.fit_done) state_n = UPDATE;
            UPDATE:    state_n = last_win ? FINISH : ARM;
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        result_valid  = (state == FINISH);
        fit.fit_start = (state == ARM) && fit.fit_done && !wdog_hit;
        fit.fit_si    = cur_si;
        fit.fit_ei    = cur_si + win_q;
        trk_clr       = (state == IDLE) && go;
        trk_load      = (state == UPDATE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            len_q     <= '0;
            win_q     <= '0;
            stride_q  <= '0;
            cur_si    <= '0;
            err       <= 1'b0;
            win_count <= '0;
            wdog      <= '0;
        end else begin
            case (state)
                IDLE: if (go) begin
                    len_q     <= cfg_len;
                    win_q     <= cfg_win;
                    stride_q  <= cfg_stride;
                    err       <= 1'b0;
                    win_count <= '0;
                end
                CHECK: begin
                    if (cfg_bad) err    <= 1'b1;
                    else         cur_si <= '0;
                end
                UPDATE: begin
                    win_count <= win_count + 1'b1;
                    if (!last_win) cur_si <= next_si[TSP_W-1:0];
                end
                default: ;
            endcase
            if (wdog_hit) err <= 1'b1;
            if ((state_n == ARM) && (state != ARM)) wdog <= '0;
            else if (counting)                      wdog <= wdog + 1'b1;
        end
    end

    fit_best_tracker u_tracker (
        .Clk       (Clk),
        .Rst       (Rst),
        .clr       (trk_clr),
        .load      (trk_load),
        .cand_si   (cur_si),
        .cand_dev  (fit.fit_deviation),
        .cand_mean (fit.fit_mean),
        .best_si   (best_si),
        .best_dev  (best_dev),
        .best_mean (best_mean)
    );

endmodule

// File: tb/tb_fit_window_sweep.sv
// Scoreboard bench for fit_window_sweep against a behavioural LinFitDev engine model.
module tb_fit_window_sweep;
    import tsp_pkg::*;

    localparam int TO  = 20;
    localparam int RUN = 10;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        go  = 1'b0;
    logic [31:0] cfg_len = '0, cfg_win = '0, cfg_stride = '0;
    logic        busy, result_valid, err;
    logic [31:0] best_si, best_dev, best_mean, win_count;

    fit_window_sweep_if fit();

    fit_window_sweep #(.TIMEOUT(TO)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .go           (go),
        .cfg_len      (cfg_len),
        .cfg_win      (cfg_win),
        .cfg_stride   (cfg_stride),
        .busy         (busy),
        .result_valid (result_valid),
        .err          (err),
        .best_si      (best_si),
        .best_dev     (best_dev),
        .best_mean    (best_mean),
        .win_count    (win_count),
        .fit          (fit)
    );

    always #5 Clk = ~Clk;

    int checks = 0, failures = 0;
    int cyc = 0, go_cyc = 0, last_start_cyc = 0;
    int n_starts = 0, n_results = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Engine model: done drops the cycle after start, returns after RUN cycles.
    logic        eng_done = 1'b1;
    int          eng_cnt  = 0;
    bit          eng_hang = 1'b0;
    logic [31:0] eng_dev  = '0, eng_mean = '0;
    logic [31:0] dev_q[$];

    assign fit.fit_done      = eng_done;
    assign fit.fit_deviation = eng_dev;
    assign fit.fit_mean      = eng_mean;

    always @(posedge Clk) begin
        if (fit.fit_start && eng_done) begin
            eng_done <= 1'b0;
            eng_cnt  <= RUN;
            eng_dev  <= (dev_q.size() != 0) ? dev_q.pop_front() : 32'hDEAD;
            eng_mean <= fit.fit_si + 32'h100;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && !eng_hang) eng_done <= 1'b1;
        end
    end

    typedef struct {
        logic [31:0] si;
        logic [31:0] ei;
        int          go_lat;
    } win_t;

    typedef struct {
        logic        err;
        logic [31:0] si;
        logic [31:0] dev;
        logic [31:0] mean;
        logic [31:0] cnt;
        bit          chk_mean;
        int          lat_kind;   // 0 none, 1 from go, 2 from last start
        int          lat;
    } res_t;

    win_t exp_win_q[$];
    res_t exp_res_q[$];

    always @(negedge Clk) begin : monitor
        win_t w;
        res_t r;
        if (!Rst) begin
            if (fit.fit_start) begin
                n_starts++;
                last_start_cyc = cyc;
                check_eq("start_engine_idle", fit.fit_done, 1);
                check_eq("start_expected", exp_win_q.size() != 0, 1);
                if (exp_win_q.size() != 0) begin
                    w = exp_win_q.pop_front();
                    check_eq("fit_si", fit.fit_si, w.si);
                    check_eq("fit_ei", fit.fit_ei, w.ei);
                    if (w.go_lat >= 0) check_eq("go_to_start", cyc - go_cyc, w.go_lat);
                end
            end
            if (result_valid) begin
                n_results++;
                check_eq("result_expected", exp_res_q.size() != 0, 1);
                if (exp_res_q.size() != 0) begin
                    r = exp_res_q.pop_front();
                    check_eq("err", err, r.err);
                    check_eq("best_si", best_si, r.si);
                    check_eq("best_dev", best_dev, r.dev);
                    check_eq("win_count", win_count, r.cnt);
                    check_eq("busy_in_finish", busy, 1);
                    if (r.chk_mean) check_eq("best_mean", best_mean, r.mean);
                    if (r.lat_kind == 1) check_eq("go_to_result", cyc - go_cyc, r.lat);
                    if (r.lat_kind == 2) check_eq("start_to_result", cyc - last_start_cyc, r.lat);
                end
            end
        end
    end

    task automatic start_sweep(input logic [31:0] len, input logic [31:0] win,
                               input logic [31:0] stride, input int first_lat,
                               input bit expect_timeout);
        res_t        r;
        win_t        w;
        logic [63:0] si;
        int          k;
        r.err = 1'b0; r.si = '0; r.dev = DEV_MAX; r.mean = '0; r.cnt = '0;
        r.chk_mean = 1'b0; r.lat_kind = 0; r.lat = 0;
        if (win == 0 || stride == 0 || win > len) begin
            r.err = 1'b1; r.lat_kind = 1; r.lat = 2;
        end else if (expect_timeout) begin
            w.si = '0; w.ei = win; w.go_lat = first_lat;
            exp_win_q.push_back(w);
            r.err = 1'b1; r.lat_kind = 2; r.lat = TO;
        end else begin
            si = '0;
            k  = 0;
            while ((si + {32'b0, win}) <= {32'b0, len} && k < dev_q.size()) begin
                w.si = si[31:0]; w.ei = si[31:0] + win; w.go_lat = (k == 0) ? first_lat : -1;
                exp_win_q.push_back(w);
                if (dev_q[k] < r.dev) begin
                    r.dev = dev_q[k]; r.si = si[31:0]; r.mean = si[31:0] + 32'h100; r.chk_mean = 1'b1;
                end
                k++;
                si = si + {32'b0, stride};
            end
            r.cnt = k;
        end
        exp_res_q.push_back(r);
        @(negedge Clk);
        cfg_len = len; cfg_win = win; cfg_stride = stride;
        go = 1'b1;
        go_cyc = cyc;
        @(negedge Clk);
        go = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int budget);
        int n0;
        n0 = n_results - ((result_valid === 1'b1) ? 1 : 0);
        for (int i = 0; i < budget && n_results == n0; i++) begin
            @(negedge Clk);
            #1;
        end
        check_eq({tag, "_result_seen"}, n_results, n0 + 1);
        repeat (3) @(negedge Clk);
        #1;
        check_eq({tag, "_single_result"}, n_results, n0 + 1);
        check_eq({tag, "_busy_dropped"}, busy, 0);
        check_eq({tag, "_windows_left"}, exp_win_q.size(), 0);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n0;
        n0 = n_starts;
        for (int i = 0; i < budget && n_starts == n0; i++) begin
            @(negedge Clk);
            #1;
        end
        check_eq({tag, "_start_seen"}, n_starts, n0 + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_result_valid"}, result_valid, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_best_si"}, best_si, 0);
        check_eq({tag, "_best_dev"}, best_dev, 0);
        check_eq({tag, "_best_mean"}, best_mean, 0);
        check_eq({tag, "_win_count"}, win_count, 0);
        check_eq({tag, "_fit_si"}, fit.fit_si, 0);
        check_eq({tag, "_fit_ei"}, fit.fit_ei, 0);
        check_eq({tag, "_fit_start"}, fit.fit_start, 0);
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge Clk);
        check_reset_outputs("por");
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Basic sweep: windows at 0,2,4, best at si=2
        dev_q.push_back(5); dev_q.push_back(3); dev_q.push_back(7);
        start_sweep(8, 4, 2, 2, 1'b0);
        wait_result("basic", 200);

        // Tie keeps the earliest window
        dev_q.push_back(4); dev_q.push_back(4);
        start_sweep(6, 4, 2, 2, 1'b0);
        wait_result("tie", 200);

        // Invalid configurations never reach the engine
        s0 = n_starts;
        start_sweep(8, 0, 2, -1, 1'b0);
        wait_result("win0", 20);
        start_sweep(8, 4, 0, -1, 1'b0);
        wait_result("stride0", 20);
        start_sweep(8, 9, 1, -1, 1'b0);
        wait_result("win_gt_len", 20);
        check_eq("invalid_no_start", n_starts, s0);
        check_eq("invalid_err_held", err, 1);

        // Near-full-range window: next start must not wrap back into range
        dev_q.push_back(1);
        start_sweep(32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'h20, 2, 1'b0);
        wait_result("overflow", 200);

        // Reset during WAIT_DONE while the engine is still running
        dev_q.push_back(6); dev_q.push_back(6);
        start_sweep(8, 4, 4, 2, 1'b0);
        wait_start("abort", 20);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check_reset_outputs("midrst");
        exp_win_q.delete();
        exp_res_q.delete();
        dev_q.delete();
        dev_q.push_back(9); dev_q.push_back(2);
        start_sweep(8, 4, 4, -1, 1'b0);
        wait_start("restart", 50);
        check_eq("restart_stalled", (last_start_cyc - go_cyc) > 2, 1);
        wait_result("restart", 200);

        // Engine never finishes: watchdog aborts, best_* untouched
        eng_hang = 1'b1;
        dev_q.push_back(5);
        start_sweep(8, 4, 4, 2, 1'b1);
        wait_result("timeout", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_time_limit: got no completion expected completion before 100000");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fit_window_sweep.md
# fit_window_sweep

Sliding-window scheduler for the linear-fit/deviation engine (`LinFitDev`). On `go` it latches a series length, window width and stride. It then issues one fit per window position to the engine through its `si`/`ei`/`start`/`done` handshake and keeps the window with the smallest deviation. This is the block that sequences the fit engine inside the timeseries predictor. The engine's value-memory port stays wired directly to the engine.

## Interface
Parameters:
- `TIMEOUT`, default 65535: maximum cycles to wait for the engine to finish one fit before the sweep aborts with an error.

Ports:
- `Clk` in 1: clock; all logic is rising-edge.
- `Rst` in 1: synchronous, active-high reset.
- `go` in 1: start a sweep. Sampled only in IDLE.
- `cfg_len` in 32: number of samples; valid indices are 0..len-1.
- `cfg_win` in 32: window width, i.e. `ei-si`.
- `cfg_stride` in 32: step size between consecutive window starts.
- `busy` out 1: high from the cycle after `go` is accepted until FINISH completes.
- `result_valid` out 1: one-cycle pulse when a sweep completes, whether OK or error.
- `err` out 1: status of the last sweep; held until the next `go` is accepted.
- `best_si` out 32: start index of the best window.
- `best_dev` out 32: deviation of the best window.
- `best_mean` out 32: mean reported with the best window.
- `win_count` out 32: number of fits completed in the last sweep.
- `fit_si`, `fit_ei` out 32: window bounds driven to the engine.
- `fit_start` out 1: one-cycle start pulse to the engine.
- `fit_done` in 1: engine done flag. It is high when the engine is idle and drops one cycle after `start`.
- `fit_deviation`, `fit_mean` in 32: engine results, valid while `fit_done` is high after a run.

## Operation
- Reset values: all outputs 0; state IDLE.
- **IDLE**
  - On `go`, latch the three cfg inputs, clear `err` and `win_count`, set `best_dev` to 0xFFFFFFFF and `best_si` to 0, then go to CHECK.
  - `go` is ignored in every other state.
- **CHECK**
  - Set `err` and go to FINISH if `cfg_win == 0`, `cfg_stride == 0`, or `cfg_win > cfg_len`.
  - Otherwise set `cur_si` to 0 and go to ARM.
- **ARM**
  - Wait here until `fit_done == 1`; this covers an engine still running after a reset.
  - Drive `fit_si = cur_si` and `fit_ei = cur_si + cfg_win`.
  - Pulse `fit_start` for exactly one cycle, then go to WAIT_LOW.
- **WAIT_LOW**: wait one cycle for the engine to clear `done`, then go to WAIT_DONE. `fit_done` is ignored in this cycle.
- **WAIT_DONE**: when `fit_done == 1`, go to UPDATE.
- **UPDATE**
  - Increment `win_count`.
  - If `fit_deviation < best_dev` (strictly less), load `best_dev`, `best_mean` and `best_si = cur_si`. Ties therefore keep the earliest window.
  - Compute `next = cur_si + cfg_stride` in 33 bits.
  - If `next + cfg_win > cfg_len` (34-bit compare), go to FINISH. Otherwise set `cur_si = next` and go to ARM.
- **FINISH**: pulse `result_valid` for one cycle, drop `busy`, return to IDLE.
- **Timeout**
  - A 32-bit watchdog clears on entry to ARM and counts in ARM, WAIT_LOW and WAIT_DONE.
  - When it reaches `TIMEOUT`, set `err` and go to FINISH. The `best_*` values gathered so far are kept.
- `fit_si` and `fit_ei` hold their values between ARM and UPDATE. The engine reads `si`/`ei` while it runs.

## Timing
- Per window: ARM takes 1 cycle, WAIT_LOW 1 cycle, the engine run, then UPDATE 1 cycle.
- Overhead is therefore 3 cycles per window, plus 1 cycle for CHECK and 1 for FINISH.
- `go` → `busy` high: 1 cycle.
- `go` → first `fit_start`: 2 cycles, provided the engine is idle.
- Last UPDATE → `result_valid`: 1 cycle.
- Reset mid-sweep: all outputs return to their reset values on the next edge and no `result_valid` is emitted. The next sweep stalls in ARM until the engine reports done.
- Windows issued = floor((len − win)/stride) + 1 when the configuration is valid.

## Structure
- Shared package `tsp_pkg`:
  - state encoding `sweep_state_t`, 3 bits: IDLE, CHECK, ARM, WAIT_LOW, WAIT_DONE, UPDATE, FINISH;
  - `DEV_MAX = 32'hFFFFFFFF`;
  - data width constant `TSP_W = 32`.
- One natural sub-module, `fit_best_tracker`: the compare-and-hold of `best_dev`/`best_mean`/`best_si` with clear and load strobes.
- FSM, window counter and watchdog live in the top module.

## Test plan
- Behavioural engine model with a fixed 10-cycle run; len=8, win=4, stride=2; deviations returned 5,3,7.
  - Required: windows issued at si=0,2,4; `best_si`=2; `best_dev`=3; `win_count`=3; `err`=0; one `result_valid`.
- Equal deviations 4,4 with len=6, win=4, stride=2.
  - Required: `best_si`=0 (earliest tie kept); `win_count`=2.
- Invalid configurations: win=0; stride=0; win=9 with len=8.
  - Required for each: no `fit_start`; `err`=1; `result_valid` 2 cycles after `go`; `win_count`=0.
- Overflow guard: len=0xFFFFFFFF, win=0xFFFFFFF0, stride=0x20.
  - Required: exactly one window issued, at si=0; no wrap-around reissue.
- TIMEOUT=20 with the engine model holding `done` low forever after the first start.
  - Required: `err`=1 and `result_valid` 20 cycles after ARM entry; `best_dev`=0xFFFFFFFF.
- `Rst` asserted during WAIT_DONE while the engine is still busy, then `go` issued.
  - Required: outputs zero after reset; the new first `fit_start` appears only after the engine raises `fit_done`.
